// File: rtl/elevator_scan.sv
// elevator_scan: SCAN-scheduled elevator controller with door dwell, travel timing and emergency stop
module elevator_scan #(
  parameter int NUM_FLOORS = 8,
  parameter int FLOOR_W = 3,
  parameter int T_DOOR = 300000000,
  parameter int T_ACCEL = 300000000,
  parameter int T_FLOOR = 500000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [NUM_FLOORS-1:0] hall_req,
  input  logic                  open_door,
  input  logic                  close_door,
  input  logic                  sense_door,
  input  logic                  sos_req,
  output logic [FLOOR_W-1:0]    floor,
  output logic                  dir,
  output logic [2:0]            state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  status_door,
  output logic                  sos_en
);
  typedef enum logic [2:0] {IDLE, OPEN, CLOSE, ACCEL, RUN, DECEL, SOS} st_t;
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  st_t st;
  logic [31:0] cnt;
  logic [NUM_FLOORS-1:0] cur, nxt_bit, latched, ahead_mask;
  logic [FLOOR_W-1:0] nxt;
  logic ahead, at_end, door_end, accel_end, floor_end;
  always_comb begin
    cur = ONE << floor;
    ahead_mask = dir ? cur - ONE : ~((cur << 1) - ONE);
    ahead = |(pending & ahead_mask);
    at_end = dir ? floor == '0 : floor == FLOOR_W'(NUM_FLOORS-1);
    nxt = dir ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
    nxt_bit = ONE << nxt;
    latched = pending | car_req | hall_req;
    door_end = cnt == 32'(T_DOOR-1);
    accel_end = cnt == 32'(T_ACCEL-1);
    floor_end = cnt == 32'(T_FLOOR-1);
  end
  assign state = st;
  assign status_door = st == OPEN;
  assign sos_en = st == SOS;
  // Entering OPEN always clears the current floor's bit, overriding a same-cycle request.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      floor <= '0;
      dir <= 1'b0;
      pending <= '0;
      cnt <= '0;
    end else if (sos_req || st == SOS) begin
      st <= SOS;
      pending <= '0;
      cnt <= '0;
    end else begin
      pending <= latched;
      cnt <= cnt + 32'd1;
      case (st)
        IDLE:
          if (open_door || |(pending & cur)) begin
            st <= OPEN;
            cnt <= '0;
            pending <= latched & ~cur;
          end else if (|pending) begin
            st <= ACCEL;
            cnt <= '0;
            dir <= ahead ? dir : ~dir;
          end
        OPEN: begin
          pending <= latched & ~cur;
          if (open_door) cnt <= '0;
          else if (close_door || door_end) begin
            st <= CLOSE;
            cnt <= '0;
          end
        end
        CLOSE:
          if (sense_door || open_door) begin
            st <= OPEN;
            cnt <= '0;
            pending <= latched & ~cur;
          end else if (door_end) begin
            st <= IDLE;
            cnt <= '0;
          end
        ACCEL:
          if (accel_end) begin
            st <= RUN;
            cnt <= '0;
          end
        RUN:
          if (floor_end) begin
            cnt <= '0;
            if (at_end) st <= DECEL;
            else begin
              floor <= nxt;
              if (|(pending & nxt_bit)) st <= DECEL;
            end
          end
        DECEL:
          if (accel_end) begin
            st <= OPEN;
            cnt <= '0;
            pending <= latched & ~cur;
          end
        default: begin
          st <= IDLE;
          cnt <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_elevator_scan.sv
// tb_elevator_scan: scoreboard bench; a SCAN stop-list model predicts every door opening (floor, dir, cycle)
module tb_elevator_scan;
  localparam int NF = 8, TD = 3, TA = 2, TF = 4;
  typedef struct {int f; int d; int t;} stop_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] car_req = '0, hall_req = '0;
  logic open_door = 1'b0, close_door = 1'b0, sense_door = 1'b0, sos_req = 1'b0;
  logic [2:0] floor, state;
  logic dir, status_door, sos_en;
  logic [7:0] pending;
  stop_t exp_q[$];
  int cyc = 0, n_tests = 0, n_fail = 0, mf = 0, md = 0, idle_t = 0;
  bit prev_door = 1'b0;
  int rise_t = 0;

  elevator_scan #(.NUM_FLOORS(NF), .FLOOR_W(3), .T_DOOR(TD), .T_ACCEL(TA), .T_FLOOR(TF)) dut (
    .clk(clk), .rst(rst), .car_req(car_req), .hall_req(hall_req), .open_door(open_door),
    .close_door(close_door), .sense_door(sense_door), .sos_req(sos_req), .floor(floor),
    .dir(dir), .state(state), .pending(pending), .status_door(status_door), .sos_en(sos_en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    stop_t e;
    if (status_door && !prev_door) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_open: got door open at floor %0d expected none (cycle %0d)", floor, cyc);
      end else begin
        e = exp_q.pop_front();
        check("open_floor", int'(floor), e.f);
        check("open_dir", int'(dir), e.d);
        check("open_time", cyc, e.t);
        check("open_cleared", int'(pending[floor]), 0);
      end
      rise_t = cyc;
    end
    if (!status_door && prev_door) check("door_dwell", cyc - rise_t, TD);
    prev_door = status_door;
  end

  task automatic wait_to(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  function automatic bit has_ahead(input logic [7:0] m, input int f, input int d);
    for (int x = 0; x < NF; x++) if (m[x] && (d != 0 ? x < f : x > f)) return 1'b1;
    return 1'b0;
  endfunction

  // Requests all latched at once are served as: current floor, then everything ahead, then the rest.
  task automatic run_batch(input logic [7:0] mask, input bit reopen, input logic [7:0] extra, input int extra_off);
    logic [7:0] m, rnd;
    int sf[$], sd[$];
    int f, d, x, e, t, cur, ready, n, t1;
    stop_t s;
    m = mask | extra;
    f = mf;
    d = md;
    if (m[f]) begin sf.push_back(f); sd.push_back(d); m[f] = 1'b0; end
    if (m != 0 && !has_ahead(m, f, d)) d = 1 - d;
    for (int leg = 0; leg < 2; leg++) begin
      for (int k = 1; k < NF; k++) begin
        x = d != 0 ? f - k : f + k;
        if (x >= 0 && x < NF && m[x]) begin sf.push_back(x); sd.push_back(d); m[x] = 1'b0; end
      end
      if (m != 0) d = 1 - d;
    end
    e = cyc + 1;
    cur = mf;
    ready = e + 1;
    t1 = 0;
    foreach (sf[i]) begin
      n = sf[i] > cur ? sf[i] - cur : cur - sf[i];
      t = ready + (n == 0 ? 0 : 2 * TA + n * TF);
      s.f = sf[i]; s.d = sd[i]; s.t = t;
      exp_q.push_back(s);
      if (i == 0) t1 = t;
      if (i == 0 && reopen) begin
        t = t + TD + 2;
        s.t = t;
        exp_q.push_back(s);
      end
      ready = t + 2 * TD + 1;
      cur = sf[i];
    end
    idle_t = ready - 1;
    mf = cur;
    md = sd[sd.size() - 1];
    rnd = 8'($urandom);
    car_req = mask & rnd;
    hall_req = mask & ~rnd;
    @(negedge clk);
    car_req = '0;
    hall_req = '0;
    if (extra != 0) begin
      wait_to(e + extra_off);
      hall_req = extra;
      @(negedge clk);
      hall_req = '0;
    end
    if (reopen) begin
      wait_to(t1 + TD + 1);
      sense_door = 1'b1;
      @(negedge clk);
      sense_door = 1'b0;
    end
    wait_to(idle_t);
    check("queue_drained", exp_q.size(), 0);
    check("idle_state", int'(state), 0);
    check("idle_floor", int'(floor), mf);
    check("idle_dir", int'(dir), md);
    check("idle_pending", int'(pending), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [7:0] mask;
    repeat (3) @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_floor", int'(floor), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_door", int'(status_door), 0);
    check("rst_sos", int'(sos_en), 0);
    rst = 1'b0;
    @(negedge clk);
    run_batch(8'h08, 1'b0, 8'h00, 0);
    run_batch(8'h02, 1'b0, 8'h00, 0);
    run_batch(8'h04, 1'b0, 8'h00, 0);
    run_batch(8'h22, 1'b0, 8'h00, 0);
    run_batch(8'h10, 1'b1, 8'h00, 0);
    for (int i = 0; i < 24; i++) begin
      mask = 8'($urandom) & 8'($urandom);
      if (mask == 0) mask = 8'(1) << $urandom_range(0, 7);
      run_batch(mask, $urandom_range(0, 3) == 0, 8'h00, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mf = 0;
    md = 0;
    @(negedge clk);
    run_batch(8'h40, 1'b0, 8'h08, TA + TF + 2);
    e = cyc + 1;
    car_req = 8'h01;
    @(negedge clk);
    car_req = '0;
    wait_to(e + TA + 2 * TF + 2);
    check("run_state", int'(state), 4);
    check("run_floor", int'(floor), 4);
    check("run_dir", int'(dir), 1);
    check("run_pending", int'(pending), 1);
    rst = 1'b1;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_floor", int'(floor), 0);
    check("async_rst_dir", int'(dir), 0);
    check("async_rst_pending", int'(pending), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mf = 0;
    md = 0;
    @(negedge clk);
    e = cyc + 1;
    car_req = 8'h20;
    @(negedge clk);
    car_req = '0;
    wait_to(e + TA + 2 * TF + 2);
    check("pre_sos_floor", int'(floor), 2);
    sos_req = 1'b1;
    @(negedge clk);
    sos_req = 1'b0;
    check("sos_state", int'(state), 6);
    check("sos_en", int'(sos_en), 1);
    check("sos_floor", int'(floor), 2);
    check("sos_pending", int'(pending), 0);
    car_req = 8'hff;
    hall_req = 8'hff;
    open_door = 1'b1;
    repeat (5) @(negedge clk);
    car_req = '0;
    hall_req = '0;
    open_door = 1'b0;
    repeat (10) @(negedge clk);
    check("sos_hold_state", int'(state), 6);
    check("sos_hold_floor", int'(floor), 2);
    check("sos_hold_pending", int'(pending), 0);
    check("sos_hold_door", int'(status_door), 0);
    rst = 1'b1;
    #1;
    check("sos_exit_state", int'(state), 0);
    check("sos_exit_en", int'(sos_en), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/elevator_scan.md
ELEVATOR_SCAN -- requirements
Module: elevator_scan

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8: number of floors, legal range 2..16; floors are numbered 0..NUM_FLOORS-1.
REQ-002 SHALL have parameter FLOOR_W, default 3: floor index width, equal to ceil(log2(NUM_FLOORS)), minimum 1.
REQ-003 SHALL have parameter T_DOOR, default 300000000: door open or close dwell in cycles, minimum 1.
REQ-004 SHALL have parameter T_ACCEL, default 300000000: acceleration or deceleration dwell in cycles, minimum 1.
REQ-005 SHALL have parameter T_FLOOR, default 500000000: travel time per floor in cycles, minimum 1.
REQ-006 SHALL have the ports below, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- car_req  in  NUM_FLOORS  cabin buttons, one bit per floor, level or pulse.
- hall_req  in  NUM_FLOORS  hall buttons, one bit per floor.
- open_door  in  1  door-open button.
- close_door  in  1  door-close button.
- sense_door  in  1  obstruction sensor.
- sos_req  in  1  emergency request.
- floor  out  FLOOR_W  current (last reached) floor, binary.
- dir  out  1  travel direction: 0 = up, 1 = down.
- state  out  3  FSM state code.
- pending  out  NUM_FLOORS  latched outstanding requests.
- status_door  out  1  high iff state == OPEN.
- sos_en  out  1  high iff state == SOS.

Function
REQ-007 SHALL use these state codes: IDLE=0, OPEN=1, CLOSE=2, ACCEL=3, RUN=4, DECEL=5, SOS=6; codes 7 SHALL go to IDLE on the next cycle.
REQ-008 SHALL latch requests every cycle: pending <= pending | car_req | hall_req; once latched, a bit stays set until it is served or reset is asserted.
REQ-009 SHALL clear pending[floor] on the edge that enters OPEN; while in OPEN, request bits for the current floor SHALL NOT be latched; the clear SHALL win over a simultaneous set.
REQ-010 SHALL define "ahead" as any pending bit strictly above floor when dir=0, or strictly below floor when dir=1.
REQ-011 In IDLE, SHALL apply this priority: open_door, or pending[floor] set -> OPEN; else a pending bit ahead -> ACCEL with dir unchanged; else any pending bit -> ACCEL with dir inverted; else stay in IDLE.
REQ-012 In IDLE, close_door SHALL have no effect.
REQ-013 ACCEL SHALL last exactly T_ACCEL cycles and then go to RUN with the counter at 0.
REQ-014 In RUN, when the counter reaches T_FLOOR-1, floor SHALL change by ±1 according to dir; if pending at the new floor is set, the next state SHALL be DECEL, otherwise RUN with the counter reset.
REQ-015 SHALL serve any request latched before the counter expiry for the next floor at that floor; this includes requests raised en route.
REQ-016 DECEL SHALL last exactly T_ACCEL cycles and then go to OPEN.
REQ-017 OPEN SHALL last T_DOOR cycles and then go to CLOSE.
REQ-018 In OPEN, close_door SHALL go to CLOSE on the next cycle.
REQ-019 In OPEN, open_door SHALL restart the dwell counter at 0.
REQ-020 In CLOSE, sense_door or open_door SHALL go to OPEN with the counter at 0; otherwise CLOSE SHALL go to IDLE after T_DOOR cycles.
REQ-021 floor SHALL never leave the range 0..NUM_FLOORS-1; floor changes SHALL occur only in RUN.
REQ-022 dir SHALL change only in IDLE.
REQ-023 The dwell counter SHALL be 32 bits wide and SHALL reset to 0 on every state change.
REQ-024 sos_req SHALL force SOS on the next edge from any state.
REQ-025 In SOS, floor SHALL hold its value, pending SHALL be cleared, and requests SHALL be ignored; SOS SHALL be exited only by rst.
REQ-026 All outputs SHALL be registered or decoded only from registered state, with no combinational path from input to output.

Reset
REQ-027 While rst is high, the block SHALL hold state=IDLE, floor=0, dir=0, pending=0, counter=0, status_door=0 and sos_en=0.
REQ-028 Reset asserted mid-travel SHALL take effect immediately; the first cycle after release SHALL evaluate IDLE.

Verification (bench parameters: NUM_FLOORS=8, T_DOOR=3, T_ACCEL=2, T_FLOOR=4)
REQ-029 Reset scenario: assert rst during RUN at floor 4 -> floor=0, state=0, pending=0, dir=0 asynchronously.
REQ-030 Single trip: at floor 0, one-cycle pulse on car_req[3] -> ACCEL for 2 cycles, RUN with floor reaching 1, 2, 3 at 4-cycle intervals, DECEL for 2 cycles, then OPEN with pending[3]=0; status_door stays high for 3 cycles, then CLOSE for 3 cycles, then IDLE.
REQ-031 SCAN order: at floor 2, dir=0, pending={5,1} -> stops at floor 5 first, then reverses, sets dir=1 and stops at floor 1.
REQ-032 En-route stop: travelling 0->6, hall_req[3] is pulsed during RUN between floors 1 and 2 -> DECEL/OPEN at floor 3, then the trip continues to floor 6.
REQ-033 Door reopen: sense_door is pulsed in the 2nd cycle of CLOSE -> OPEN with a full 3-cycle dwell, then CLOSE, then IDLE.
REQ-034 Emergency: sos_req is pulsed during RUN at floor 2 -> state=6, sos_en=1, floor=2 held, pending=0, and later requests are ignored until rst.
